// File: rtl/avmm_burst_master.sv
// rtl/avmm_burst_master.sv - Avalon-MM burst master: command front end, read/write bursts, stall timeout
// Data paths are combinational pass-throughs; a write beat stalled by waitrequest is held locally.
module avmm_burst_master #(
  parameter int AW        = 16,
  parameter int DW        = 64,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 256,
  localparam int BCW      = $clog2(MAX_BURST) + 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [AW-1:0]  cmd_address,
  input  logic [BCW-1:0] cmd_burstcount,
  input  logic [DW-1:0]  wr_data,
  input  logic           wr_valid,
  output logic           wr_ready,
  output logic [DW-1:0]  rd_data,
  output logic           rd_valid,
  output logic           done,
  output logic           error,
  output logic [AW-1:0]  avm_address,
  output logic           avm_read,
  output logic           avm_write,
  output logic [BCW-1:0] avm_burstcount,
  output logic [DW-1:0]  avm_writedata,
  input  logic           avm_waitrequest,
  input  logic [DW-1:0]  avm_readdata,
  input  logic           avm_readdatavalid
);

  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [BCW-1:0] MAX_BC      = BCW'(MAX_BURST);
  localparam logic [SW-1:0]  STALL_LIMIT = SW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_BEAT, RESP} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [BCW-1:0] beat_q, beat_d;
  logic [SW-1:0]  stall_q, stall_d;
  logic           err_q, err_d;
  logic           hold_q, hold_d;
  logic [DW-1:0]  hdata_q, hdata_d;

  logic           in_rd, in_wr, busy, cmd_ok, rd_accept, progress, timeout;
  logic [BCW-1:0] beat_inc;

  assign in_rd     = (state_q == RD_CMD) || (state_q == RD_DATA);
  assign in_wr     = (state_q == WR_BEAT);
  assign busy      = in_rd || in_wr;
  assign cmd_ok    = (cmd_burstcount != '0) && (cmd_burstcount <= MAX_BC);
  assign beat_inc  = beat_q + 1'b1;

  assign cmd_ready      = (state_q == IDLE);
  assign done           = (state_q == RESP);
  assign avm_address    = addr_q;
  assign avm_burstcount = bcnt_q;
  assign avm_read       = (state_q == RD_CMD);
  assign rd_accept      = avm_read && !avm_waitrequest;

  // Read data arriving outside an active read (e.g. after a timeout) is dropped here.
  assign rd_valid = in_rd && avm_readdatavalid;
  assign rd_data  = rd_valid ? avm_readdata : '0;

  // Once a beat is presented under waitrequest it stays on the bus unchanged until taken.
  assign avm_write     = in_wr && (wr_valid || hold_q);
  assign avm_writedata = !in_wr ? '0 : (hold_q ? hdata_q : wr_data);
  assign wr_ready      = avm_write && !avm_waitrequest;

  assign progress = rd_accept || rd_valid || wr_ready;
  assign timeout  = busy && !progress && (stall_q == STALL_LIMIT);
  assign error    = err_q || timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bcnt_q  <= '0;
      beat_q  <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b0;
      hdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      hdata_q <= hdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    err_d   = 1'b0;
    hold_d  = 1'b0;
    hdata_d = hdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_ok) begin
            addr_d  = cmd_address;
            bcnt_d  = cmd_burstcount;
            beat_d  = '0;
            stall_d = '0;
            state_d = cmd_write ? WR_BEAT : RD_CMD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RD_CMD: begin
        // A beat landing together with the command accept is beat 0.
        if (rd_valid) beat_d = beat_inc;
        if (rd_accept) state_d = (rd_valid && beat_inc == bcnt_q) ? RESP : RD_DATA;
      end
      RD_DATA: begin
        if (rd_valid) begin
          beat_d = beat_inc;
          if (beat_inc == bcnt_q) state_d = RESP;
        end
      end
      WR_BEAT: begin
        hold_d  = avm_write && avm_waitrequest;
        hdata_d = avm_writedata;
        if (wr_ready) begin
          beat_d = beat_inc;
          if (beat_inc == bcnt_q) state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (busy) begin
      stall_d = progress ? '0 : stall_q + 1'b1;
      if (timeout) begin
        state_d = IDLE;
        stall_d = '0;
        hold_d  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_avmm_burst_master.sv
// tb/tb_avmm_burst_master.sv - vector table plus corner-case sequences with read/write data scoreboards
module tb_avmm_burst_master;
  localparam int AW = 16, DW = 64, MAXB = 4, TO = 8;
  localparam int BCW = $clog2(MAXB) + 1;

  logic           clock = 1'b0, reset;
  logic           cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]  cmd_address;
  logic [BCW-1:0] cmd_burstcount;
  logic [DW-1:0]  wr_data, rd_data, avm_writedata, avm_readdata;
  logic           wr_valid, wr_ready, rd_valid, done, error;
  logic [AW-1:0]  avm_address;
  logic           avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [BCW-1:0] avm_burstcount;

  always #5 clock = ~clock;

  avmm_burst_master #(.AW(AW), .DW(DW), .MAX_BURST(MAXB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    int            bc;
    int            nwait;
    logic [DW-1:0] data;
    int            exp_done;
    int            exp_err;
    int            exp_rdcyc;
    int            exp_wrcyc;
  } vec_t;

  int n_vec = 0, n_err = 0;
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] wr_q[$];
  logic [AW-1:0]  exp_addr = '0;
  logic [BCW-1:0] exp_bc = '0;
  int done_tot = 0, err_tot = 0, rdcyc_tot = 0, wrcyc_tot = 0, rdx_tot = 0, wrx_tot = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (avm_read)  rdcyc_tot++;
        if (avm_write) wrcyc_tot++;
        if (done)      done_tot++;
        if (error)     err_tot++;
        if (rd_valid) begin
          rdx_tot++;
          if (rd_q.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'd0);
          else check("rd_data", rd_data, rd_q.pop_front());
        end
        if (wr_ready) begin
          wrx_tot++;
          if (wr_q.size() == 0) check("wr_unexpected", 64'(wr_ready), 64'd0);
          else begin
            check("wr_data", avm_writedata, wr_q.pop_front());
            check("wr_addr", 64'(avm_address), 64'(exp_addr));
            check("wr_bc", 64'(avm_burstcount), 64'(exp_bc));
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input int bc);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_burstcount = BCW'(bc);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int bc, input int nwait, input logic [DW-1:0] base);
    exp_addr = a; exp_bc = BCW'(bc);
    issue(1'b0, a, bc);
    check("rd_busy_ready", 64'(cmd_ready), 64'd0);
    check("rd_cmd_addr", 64'(avm_address), 64'(a));
    check("rd_cmd_bc", 64'(avm_burstcount), 64'(bc));
    avm_waitrequest = 1'b1;
    repeat (nwait) tick();
    avm_waitrequest = 1'b0;
    tick();
    for (int i = 0; i < bc; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = base + DW'(i);
      rd_q.push_back(base + DW'(i));
      tick();
    end
    avm_readdatavalid = 1'b0;
    check("rd_done", 64'(done), 64'd1);
    tick();
    check("rd_idle_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input int bc, input int nwait, input int gap_after,
                          input logic [DW-1:0] base);
    exp_addr = a; exp_bc = BCW'(bc);
    issue(1'b1, a, bc);
    check("wr_busy_ready", 64'(cmd_ready), 64'd0);
    for (int i = 0; i < bc; i++) begin
      wr_valid = 1'b1;
      wr_data = base + DW'(i);
      wr_q.push_back(base + DW'(i));
      avm_waitrequest = 1'b1;
      repeat (nwait) tick();
      avm_waitrequest = 1'b0;
      tick();
      wr_valid = 1'b0;
      if (i + 1 == gap_after && i != bc - 1) tick();
    end
    check("wr_done", 64'(done), 64'd1);
    tick();
    check("wr_idle_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int d0, e0, r0, w0, wx0, n;
    bit found;

    vecs[0] = '{1'b0, 16'h0010, 4, 2, 64'hA,          1, 0, 3, 0};
    vecs[1] = '{1'b1, 16'h0020, 1, 0, 64'h1111_0000,  1, 0, 0, 1};
    vecs[2] = '{1'b0, 16'h0030, 1, 0, 64'h2222_0000,  1, 0, 1, 0};
    vecs[3] = '{1'b0, 16'h0034, 0, 0, 64'h0,          0, 1, 0, 0};
    vecs[4] = '{1'b1, 16'h0038, 5, 0, 64'h0,          0, 1, 0, 0};
    vecs[5] = '{1'b1, 16'h0044, 4, 1, 64'h3333_0000,  1, 0, 0, 8};
    vecs[6] = '{1'b0, 16'h0050, 3, 1, 64'h4444_0000,  1, 0, 2, 0};

    reset = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_burstcount = '0;
    wr_data = 64'hDEAD_BEEF_0000_0001; wr_valid = 0;
    avm_waitrequest = 0; avm_readdata = 64'hFFFF; avm_readdatavalid = 1'b1;
    fork monitor(); join_none
    #12;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_strobes", 64'({avm_read, avm_write, wr_ready, rd_valid, done, error}), 64'd0);
    check("rst_buses", 64'(avm_address) | 64'(avm_burstcount) | avm_writedata | rd_data, 64'd0);
    avm_readdatavalid = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    foreach (vecs[k]) begin
      d0 = done_tot; e0 = err_tot; r0 = rdcyc_tot; w0 = wrcyc_tot;
      if (vecs[k].exp_err != 0) begin
        issue(vecs[k].wr, vecs[k].addr, vecs[k].bc);
        check("rej_error", 64'(error), 64'd1);
        check("rej_ready", 64'(cmd_ready), 64'd1);
        tick();
      end else if (vecs[k].wr) begin
        do_write(vecs[k].addr, vecs[k].bc, vecs[k].nwait, 0, vecs[k].data);
      end else begin
        do_read(vecs[k].addr, vecs[k].bc, vecs[k].nwait, vecs[k].data);
      end
      tick();
      check($sformatf("v%0d_done", k), 64'(done_tot - d0), 64'(vecs[k].exp_done));
      check($sformatf("v%0d_err", k), 64'(err_tot - e0), 64'(vecs[k].exp_err));
      check($sformatf("v%0d_rdcyc", k), 64'(rdcyc_tot - r0), 64'(vecs[k].exp_rdcyc));
      check($sformatf("v%0d_wrcyc", k), 64'(wrcyc_tot - w0), 64'(vecs[k].exp_wrcyc));
      check($sformatf("v%0d_sb", k), 64'(rd_q.size() + wr_q.size()), 64'd0);
    end

    // Write with a one-cycle wr_valid bubble after the first beat.
    d0 = done_tot; w0 = wrcyc_tot; wx0 = wrx_tot;
    do_write(16'h0060, 3, 0, 1, 64'hC0DE_0000);
    tick();
    check("gap_wrcyc", 64'(wrcyc_tot - w0), 64'd3);
    check("gap_xfers", 64'(wrx_tot - wx0), 64'd3);
    check("gap_done", 64'(done_tot - d0), 64'd1);

    // Read of 2 beats where only one arrives: stall timeout.
    d0 = done_tot; e0 = err_tot;
    exp_addr = 16'h0070; exp_bc = BCW'(2);
    issue(1'b0, 16'h0070, 2);
    tick();
    avm_readdatavalid = 1'b1; avm_readdata = 64'h7777; rd_q.push_back(64'h7777);
    tick();
    avm_readdatavalid = 1'b0;
    n = 0; found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clock);
      if (error) begin found = 1; n = k; end
    end
    check("to_latency", 64'(n), 64'd8);
    tick();
    check("to_idle_ready", 64'(cmd_ready), 64'd1);
    avm_readdatavalid = 1'b1; avm_readdata = 64'hBAD;
    #3;
    check("to_late_rdv", 64'(rd_valid), 64'd0);
    tick();
    avm_readdatavalid = 1'b0;
    tick();
    check("to_err", 64'(err_tot - e0), 64'd1);
    check("to_nodone", 64'(done_tot - d0), 64'd0);

    // Reset while beat 2 of a 4-beat write is stalled on the bus.
    exp_addr = 16'h0080; exp_bc = BCW'(4);
    issue(1'b1, 16'h0080, 4);
    wr_valid = 1'b1; wr_data = 64'hD0; wr_q.push_back(64'hD0);
    tick();
    wr_data = 64'hD1; avm_waitrequest = 1'b1;
    #2;
    check("prerst_write", 64'(avm_write), 64'd1);
    reset = 1'b1;
    #1;
    check("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("arst_strobes", 64'({avm_read, avm_write, wr_ready, rd_valid, done, error}), 64'd0);
    check("arst_addr", 64'(avm_address), 64'd0);
    check("arst_bc", 64'(avm_burstcount), 64'd0);
    check("arst_wdata", avm_writedata, 64'd0);
    tick();
    wr_valid = 1'b0; avm_waitrequest = 1'b0;
    reset = 1'b0;
    tick();
    d0 = done_tot; e0 = err_tot;
    do_read(16'h0090, 1, 0, 64'h55);
    tick();
    check("postrst_done", 64'(done_tot - d0), 64'd1);
    check("postrst_err", 64'(err_tot - e0), 64'd0);

    // Back-to-back single-beat read then write.
    d0 = done_tot; e0 = err_tot;
    do_read(16'h00A0, 1, 0, 64'hAAAA);
    do_write(16'h00B0, 1, 0, 0, 64'hBBBB);
    tick();
    check("b2b_done", 64'(done_tot - d0), 64'd2);
    check("b2b_err", 64'(err_tot - e0), 64'd0);
    check("final_sb", 64'(rd_q.size() + wr_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
